// File: rtl/program_loader_pkg.sv
// Shared widths and loader state encoding for the boot-time program loader.
package program_loader_pkg;

  localparam int WORD      = 32;
  localparam int HALF_WORD = 16;

  typedef enum logic [2:0] {
    LD_LEN_LO,
    LD_LEN_HI,
    LD_DATA_LO,
    LD_DATA_HI,
    LD_CHECK,
    LD_DONE,
    LD_ERROR
  } loader_state_t;

  function automatic logic accepts_bytes(input loader_state_t s);
    return (s == LD_LEN_LO) || (s == LD_LEN_HI) || (s == LD_DATA_LO) ||
           (s == LD_DATA_HI) || (s == LD_CHECK);
  endfunction

endpackage

// File: rtl/program_loader.sv
// Byte-stream boot loader: writes little-endian half-words into program memory and
// holds the CPU in reset until the image is complete. Optional checksum: LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [WORD-1:0] BASE_ADDR      = 32'h0000_0000,
  parameter int              MAX_HALF_WORDS = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  output logic                 byte_ready_o,
  input  logic                 reload_i,
  output logic                 program_mem_write_en_o,
  output logic [HALF_WORD-1:0] instruction_o,
  output logic [WORD-1:0]      instruction_addr_o,
  output logic                 cpu_reset_o,
  output logic                 load_done_o,
  output logic                 load_error_o
);

  localparam logic [16:0] MAX_LEN = 17'(MAX_HALF_WORDS);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t LD_END = LD_CHECK;
`else
  localparam loader_state_t LD_END = LD_DONE;
`endif

  loader_state_t        state_q, state_d;
  logic [15:0]          len_q, len_d;
  logic [15:0]          index_q, index_d;
  logic [7:0]           byte_q, byte_d;   // holds LEN_LO, then each payload low byte
  logic                 we_q, we_d;
  logic [HALF_WORD-1:0] instr_q, instr_d;
  logic [WORD-1:0]      addr_q, addr_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] len_in;
  logic        rearm;

  assign accept = byte_valid_i && byte_ready_o;
  assign len_in = {byte_i, byte_q};
  assign rearm  = ((state_q == LD_DONE) || (state_q == LD_ERROR)) && reload_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= LD_LEN_LO;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_LEN_LO:  if (accept) state_d = LD_LEN_HI;
      LD_LEN_HI: begin
        if (accept) begin
          if ({1'b0, len_in} > MAX_LEN) state_d = LD_ERROR;
          else if (len_in == 16'd0)     state_d = LD_END;
          else                          state_d = LD_DATA_LO;
        end
      end
      LD_DATA_LO: if (accept) state_d = LD_DATA_HI;
      LD_DATA_HI: begin
        if (accept) state_d = (16'(index_q + 16'd1) == len_q) ? LD_END : LD_DATA_LO;
      end
`ifdef LOADER_CHECKSUM_EN
      LD_CHECK:   if (accept) state_d = (byte_i == csum_q) ? LD_DONE : LD_ERROR;
`endif
      LD_DONE, LD_ERROR: if (reload_i) state_d = LD_LEN_LO;
      default:    state_d = LD_LEN_LO;
    endcase
  end

  // The CPU is released only once the final strobe has retired, so its first fetch
  // can never race the last instruction write.
  always_comb begin
    byte_ready_o = 1'b0;
    cpu_reset_o  = 1'b0;
    load_done_o  = 1'b0;
    load_error_o = 1'b0;
    if (reset_i) begin
      byte_ready_o = accepts_bytes(state_q);
      cpu_reset_o  = (state_q == LD_DONE) && !we_q;
      load_done_o  = (state_q == LD_DONE) && !we_q;
      load_error_o = (state_q == LD_ERROR);
    end
  end

  always_comb begin
    len_d   = len_q;
    index_d = index_q;
    byte_d  = byte_q;
    we_d    = 1'b0;
    instr_d = instr_q;
    addr_d  = addr_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (accept) begin
      case (state_q)
        LD_LEN_LO: byte_d = byte_i;
        LD_LEN_HI: len_d  = len_in;
        LD_DATA_LO: begin
          byte_d = byte_i;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_i;
`endif
        end
        LD_DATA_HI: begin
          we_d    = 1'b1;
          instr_d = {byte_i, byte_q};
          addr_d  = BASE_ADDR + WORD'({index_q, 1'b0});
          index_d = index_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ byte_i;
`endif
        end
        default: ;
      endcase
    end
    if (rearm) begin
      index_d = 16'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      len_q   <= 16'd0;
      index_q <= 16'd0;
      byte_q  <= 8'd0;
      we_q    <= 1'b0;
      instr_q <= '0;
      addr_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      len_q   <= len_d;
      index_q <= index_d;
      byte_q  <= byte_d;
      we_q    <= we_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign program_mem_write_en_o = we_q;
  assign instruction_o          = instr_q;
  assign instruction_addr_o     = addr_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a byte-count level reference model and a
// per-cycle compare process. Works with or without LOADER_CHECKSUM_EN.
module tb_program_loader;

  localparam logic [31:0] TB_BASE = 32'h0000_0100;
  localparam int          TB_MAX  = 4;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_ready_o;
  logic        reload_i = 1'b0;
  logic        program_mem_write_en_o;
  logic [15:0] instruction_o;
  logic [31:0] instruction_addr_o;
  logic        cpu_reset_o;
  logic        load_done_o;
  logic        load_error_o;

  program_loader #(.BASE_ADDR(TB_BASE), .MAX_HALF_WORDS(TB_MAX)) dut (
    .clk_i                  (clk_i),
    .reset_i                (reset_i),
    .byte_valid_i           (byte_valid_i),
    .byte_i                 (byte_i),
    .byte_ready_o           (byte_ready_o),
    .reload_i               (reload_i),
    .program_mem_write_en_o (program_mem_write_en_o),
    .instruction_o          (instruction_o),
    .instruction_addr_o     (instruction_addr_o),
    .cpu_reset_o            (cpu_reset_o),
    .load_done_o            (load_done_o),
    .load_error_o           (load_error_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks how many bytes of the current image were accepted and
  // derives every output from that count and the stream rules.
  typedef enum {M_LOAD, M_DONE, M_ERR} mst_t;
  mst_t        m_st    = M_LOAD;
  int          m_cnt   = 0;
  int          m_len   = 0;
  logic [7:0]  m_lo    = 8'h00;
  logic [7:0]  m_xor   = 8'h00;
  logic        m_we    = 1'b0;
  logic [15:0] m_instr = 16'h0;
  logic [31:0] m_addr  = 32'h0;
  logic        m_ck    = 1'b0;
  int          n;

  initial begin
`ifdef LOADER_CHECKSUM_EN
    m_ck = 1'b1;
`endif
  end

  always @(posedge clk_i) begin
    m_we <= 1'b0;
    if (!reset_i) begin
      m_st <= M_LOAD; m_cnt <= 0; m_xor <= 8'h00;
    end else if (m_st != M_LOAD) begin
      if (reload_i) begin
        m_st <= M_LOAD; m_cnt <= 0; m_xor <= 8'h00;
      end
    end else if (byte_valid_i) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 0) begin
        m_lo <= byte_i;
      end else if (m_cnt == 1) begin
        n = {16'h0, byte_i, m_lo};
        m_len <= n;
        if (n > TB_MAX)             m_st <= M_ERR;
        else if (n == 0 && !m_ck)   m_st <= M_DONE;
      end else if (m_cnt < 2 + 2 * m_len) begin
        m_xor <= m_xor ^ byte_i;
        if (m_cnt % 2 == 0) begin
          m_lo <= byte_i;
        end else begin
          m_we    <= 1'b1;
          m_instr <= {byte_i, m_lo};
          m_addr  <= TB_BASE + 32'(2 * ((m_cnt - 3) / 2));
          if (m_cnt == 1 + 2 * m_len && !m_ck) m_st <= M_DONE;
        end
      end else begin
        m_st <= (byte_i == m_xor) ? M_DONE : M_ERR;
      end
    end
  end

  logic [31:0] wr_addr[$];
  logic [15:0] wr_instr[$];

  always @(negedge clk_i) begin
    check("status{rdy,cpu_rst,done,err,we}",
          {27'h0, byte_ready_o, cpu_reset_o, load_done_o, load_error_o, program_mem_write_en_o},
          {27'h0, reset_i && m_st == M_LOAD,
                  reset_i && m_st == M_DONE && !m_we,
                  reset_i && m_st == M_DONE && !m_we,
                  reset_i && m_st == M_ERR,
                  m_we});
    if (m_we) begin
      check("instr", {16'h0, instruction_o}, {16'h0, m_instr});
      check("addr", instruction_addr_o, m_addr);
    end
    if (program_mem_write_en_o === 1'b1) begin
      wr_addr.push_back(instruction_addr_o);
      wr_instr.push_back(instruction_o);
    end
  end

  // Driver: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    int   tries;
    byte_valid_i = 1'b0;
    repeat (gap) step();
    byte_valid_i = 1'b1;
    byte_i = b;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      @(negedge clk_i);
      acc = byte_ready_o;
      step();
      tries++;
    end
    if (!acc) check("accept_timeout", {31'h0, acc}, 32'h1);
    byte_valid_i = 1'b0;
  endtask

  logic [7:0] stim[$];

  task automatic add_csum();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < stim.size(); i++) x ^= stim[i];
    stim.push_back(x);
`endif
  endtask

  task automatic load(input int gap);
    for (int i = 0; i < stim.size(); i++) send_byte(stim[i], gap);
    stim.delete();
  endtask

  task automatic reload();
    reload_i = 1'b1;
    step();
    reload_i = 1'b0;
  endtask

  int base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset: everything low, CPU held in reset.
    repeat (3) step();
    check("reset_outputs", {26'h0, byte_ready_o, cpu_reset_o, load_done_o, load_error_o,
                            program_mem_write_en_o, 1'b0}, 32'h0);
    reset_i = 1'b1;
    step();
    check("ready_after_reset", {31'h0, byte_ready_o}, 32'h1);

    // Two half-words, back to back.
    base = wr_addr.size();
    stim = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    add_csum();
    load(0);
    step();
    check("t1_writes", 32'(wr_addr.size() - base), 32'd2);
    check("t1_addr0", wr_addr[base], 32'h100);
    check("t1_instr0", {16'h0, wr_instr[base]}, 32'h1234);
    check("t1_addr1", wr_addr[base+1], 32'h102);
    check("t1_instr1", {16'h0, wr_instr[base+1]}, 32'h5678);
    check("t1_done", {29'h0, cpu_reset_o, load_done_o, byte_ready_o}, 32'b110);

    // Reload releases the image: CPU back in reset, ready again.
    reload();
    check("reload_cpu_reset", {31'h0, cpu_reset_o}, 32'h0);
    check("reload_ready", {31'h0, byte_ready_o}, 32'h1);

    // Same stream with valid low every other cycle.
    base = wr_addr.size();
    stim = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    add_csum();
    load(1);
    step();
    check("t2_writes", 32'(wr_addr.size() - base), 32'd2);
    check("t2_addr1", wr_addr[base+1], 32'h102);
    check("t2_instr1", {16'h0, wr_instr[base+1]}, 32'h5678);
    check("t2_done", {31'h0, load_done_o}, 32'h1);

    // Oversize length.
    reload();
    base = wr_addr.size();
    stim = '{8'h05, 8'h00};
    load(0);
    repeat (2) step();
    check("t3_error", {29'h0, load_error_o, cpu_reset_o, byte_ready_o}, 32'b100);
    check("t3_writes", 32'(wr_addr.size() - base), 32'd0);

    // Largest legal image.
    reload();
    base = wr_addr.size();
    stim = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    add_csum();
    load(0);
    step();
    check("t4_writes", 32'(wr_addr.size() - base), 32'd4);
    check("t4_addr3", wr_addr[base+3], 32'h106);
    check("t4_instr3", {16'h0, wr_instr[base+3]}, 32'h8877);
    check("t4_done", {31'h0, load_done_o}, 32'h1);

    // Zero length.
    reload();
    base = wr_addr.size();
    stim = '{8'h00, 8'h00};
    add_csum();
    load(0);
    step();
    check("t5_done", {31'h0, load_done_o}, 32'h1);
    check("t5_writes", 32'(wr_addr.size() - base), 32'd0);

`ifndef LOADER_CHECKSUM_EN
    // A trailing byte is never consumed in DONE.
    byte_valid_i = 1'b1;
    byte_i = 8'hEE;
    repeat (3) step();
    check("t6_trailing_ready", {31'h0, byte_ready_o}, 32'h0);
    byte_valid_i = 1'b0;
`else
    // Checksum match, then mismatch.
    reload();
    stim = '{8'h01, 8'h00, 8'h34, 8'h12, 8'h26};
    load(0);
    step();
    check("t7a_done", {30'h0, load_done_o, load_error_o}, 32'b10);
    reload();
    base = wr_addr.size();
    stim = '{8'h01, 8'h00, 8'h34, 8'h12, 8'h27};
    load(0);
    step();
    check("t7b_error", {29'h0, load_done_o, load_error_o, cpu_reset_o}, 32'b010);
    check("t7b_writes", 32'(wr_addr.size() - base), 32'd1);
    check("t7b_addr", wr_addr[base], 32'h100);
`endif

    // Reset in the middle of an image, then a fresh load with reload ignored mid-stream.
    reload();
    stim = '{8'h03, 8'h00, 8'h34};
    load(0);
    reset_i = 1'b0;
    repeat (2) step();
    check("t8_reset_outputs", {27'h0, byte_ready_o, cpu_reset_o, load_done_o, load_error_o,
                               program_mem_write_en_o}, 32'h0);
    reset_i = 1'b1;
    base = wr_addr.size();
    reload_i = 1'b1;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    reload_i = 1'b0;
    send_byte(8'hCD, 0);
    send_byte(8'hAB, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h66, 0);
`endif
    step();
    check("t8_writes", 32'(wr_addr.size() - base), 32'd1);
    check("t8_addr", wr_addr[base], 32'h100);
    check("t8_instr", {16'h0, wr_instr[base]}, 32'hABCD);
    check("t8_done", {31'h0, cpu_reset_o}, 32'h1);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader upstream of the CPU top level. Accepts a byte stream over a valid/ready handshake, assembles little-endian 16-bit Thumb half-words, and drives the CPU's program-memory write port (write enable, instruction, instruction address). Holds the CPU in reset until the whole image is written, then releases it. Re-arms on request.

## Interface
- BASE_ADDR, 32'h0000_0000: address of the first half-word written.
- MAX_HALF_WORDS, 1024: largest accepted image length in half-words.
- clk_i  input  1  clock; all state changes on the rising edge.
- reset_i  input  1  reset, synchronous, active-low.
- byte_valid_i  input  1  `byte_i` holds a valid byte.
- byte_i  input  8  stream byte.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- reload_i  input  1  restarts loading; sampled only in DONE or ERROR.
- program_mem_write_en_o  output  1  one-cycle write strobe to instruction memory.
- instruction_o  output  HALF_WORD  half-word to write.
- instruction_addr_o  output  WORD  byte address of the half-word.
- cpu_reset_o  output  1  CPU reset, active-low; 0 while loading.
- load_done_o  output  1  image loaded; CPU released.
- load_error_o  output  1  bad length or checksum.

## Operation
- A byte is accepted on a cycle where `byte_valid_i && byte_ready_o`.
- Stream format: LEN_LO, LEN_HI (16-bit half-word count N, little-endian), then N pairs of (low byte, high byte), then an optional checksum byte (see Configuration).
- States:
  - LEN_LO → LEN_HI on accept.
  - LEN_HI on accept:
    - N > MAX_HALF_WORDS → ERROR.
    - N == 0 → CHECK if enabled, else DONE.
    - otherwise → DATA_LO.
  - DATA_LO → DATA_HI on accept; latches the low byte.
  - DATA_HI on accept:
    - issues a write.
    - increments the index.
    - if index + 1 == N → CHECK if enabled, else DONE; otherwise → DATA_LO.
  - CHECK → DONE or ERROR on accept.
  - DONE, ERROR → LEN_LO when `reload_i`; index clears.
- `byte_ready_o` = 1 in LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK. It is 0 in DONE, in ERROR, and while `reset_i` is low.
- Write address = BASE_ADDR + 2·index. The index is 16 bits and never exceeds MAX_HALF_WORDS, so no wrap occurs. The address is computed at WORD width, modulo 2^32.
- `instruction_o` = {high byte, low byte}.
- `cpu_reset_o` = 1 only in DONE. `load_done_o` = 1 only in DONE. `load_error_o` = 1 only in ERROR.
- Bytes offered while `byte_ready_o` = 0 are not consumed; they are not dropped internally.
- `reload_i` in any other state is ignored.

## Timing
- Reset state: LEN_LO, index 0, checksum 0. All outputs are 0 while `reset_i` is low, including `cpu_reset_o`, so the CPU is held in reset.
- Reset asserted mid-load: abandons the image and returns to LEN_LO on the next edge. Words already written remain in memory.
- `program_mem_write_en_o`, `instruction_o` and `instruction_addr_o` are registered. The write strobe is high for exactly the cycle after the high byte is accepted.
- Back-to-back writes are at least 2 cycles apart, because each half-word needs two accepts.
- Entering DONE after the final write: `cpu_reset_o` rises no earlier than the cycle after the final strobe.
- On `reload_i` in DONE: `cpu_reset_o` falls on the next edge.
- Throughput: one byte per cycle. No bubble is inserted.

## Configuration
- Macro `LOADER_CHECKSUM_EN`.
- Defined:
  - A checksum register XORs every payload byte, excluding length bytes.
  - CHECK state expects a byte equal to that XOR. Match → DONE; mismatch → ERROR, with the CPU kept in reset.
  - The checksum clears on reset and on reload.
- Undefined:
  - CHECK state and checksum register are absent.
  - The last data byte or a zero length goes directly to DONE.
  - Any trailing byte waits unconsumed, since ready = 0.

## Structure
- The loader state enum goes in GENERAL_DEFS.svh next to the existing pipeline signal typedefs.
- Widths use the existing WORD and HALF_WORD constants.
- Single module; no sub-module is warranted.
- The top level muxes its program-memory write port between this block and the normal fetch path, as it does today.

## Test plan
- Load 2 half-words.
  - Stimulus: stream 02 00 34 12 78 56, one byte per cycle, checksum disabled.
  - Required: strobes with (addr 0x0, instr 0x1234) and (addr 0x2, instr 0x5678). Then DONE, `cpu_reset_o` = 1, `byte_ready_o` = 0.
- Backpressure.
  - Stimulus: the same stream with `byte_valid_i` toggling every other cycle and BASE_ADDR = 0x100.
  - Required: identical writes at 0x100 and 0x102. No write while valid is low.
- Oversize length.
  - Stimulus: MAX_HALF_WORDS = 4, stream 05 00.
  - Required: ERROR, `load_error_o` = 1, no write strobes, `cpu_reset_o` = 0.
- Checksum (`LOADER_CHECKSUM_EN`).
  - Stimulus A: 01 00 34 12 26.
  - Required A: DONE.
  - Stimulus B: 01 00 34 12 27.
  - Required B: ERROR. The write to address 0 still occurred.
- Zero length.
  - Stimulus: 00 00, checksum disabled.
  - Required: DONE with no strobes.
- Reset and reload.
  - Stimulus: assert `reset_i` = 0 after 03 00 34.
  - Required: outputs 0, then reload from LEN_LO succeeds.
  - Stimulus: pulse `reload_i` in DONE.
  - Required: `cpu_reset_o` 1→0 next cycle, `byte_ready_o` = 1.
